program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter_if.sv | 22 ++
 rtl/program_counter.sv | 61 ++++++
 tb/tb_program_counter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/program_counter_if.sv
// Bus between the program counter and its user: load request in, PC views out.
// LoadCount exists only when PC_LOAD_COUNT_EN is defined.
interface program_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             EN;
    logic [WIDTH-1:0] PCNext;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PCOld;
    logic [WIDTH-1:0] PCPlus1;
`ifdef PC_LOAD_COUNT_EN
    logic [15:0]      LoadCount;
`endif

`ifdef PC_LOAD_COUNT_EN
    modport master (output EN, PCNext, input PC, PCOld, PCPlus1, LoadCount);
    modport slave  (input EN, PCNext, output PC, PCOld, PCPlus1, LoadCount);
`else
    modport master (output EN, PCNext, input PC, PCOld, PCPlus1);
    modport slave  (input EN, PCNext, output PC, PCOld, PCPlus1);
`endif
endinterface

// File: rtl/program_counter.sv
// Program counter with previous-value shadow and combinational PC+1; loads take 1 cycle,
// no backpressure. Define PC_LOAD_COUNT_EN to add a saturating 16-bit load counter.
module program_counter #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clock,
    input  logic             reset,
    program_counter_if.slave pc_if
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_old_q;
    logic [WIDTH-1:0] pc_old_d;

    // A load with PCNext equal to PC still shifts the old value into PCOld.
    always_comb begin
        pc_d     = pc_q;
        pc_old_d = pc_old_q;
        if (pc_if.EN) begin
            pc_d     = pc_if.PCNext;
            pc_old_d = pc_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_VECTOR;
            pc_old_q <= RESET_VECTOR;
        end else begin
            pc_q     <= pc_d;
            pc_old_q <= pc_old_d;
        end
    end

    assign pc_if.PC      = pc_q;
    assign pc_if.PCOld   = pc_old_q;
    assign pc_if.PCPlus1 = pc_q + WIDTH'(1);

`ifdef PC_LOAD_COUNT_EN
    logic [15:0] load_cnt_q;
    logic [15:0] load_cnt_d;

    always_comb begin
        load_cnt_d = load_cnt_q;
        if (pc_if.EN && (load_cnt_q != 16'hFFFF)) begin
            load_cnt_d = load_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_cnt_q <= 16'd0;
        end else begin
            load_cnt_q <= load_cnt_d;
        end
    end

    assign pc_if.LoadCount = load_cnt_q;
`endif
endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reset, hold, load, wrap, back-to-back and async reset.
module tb_program_counter;
    logic clock;
    logic reset;
    int   errors;
    int   checks;

    program_counter_if #(.WIDTH(8)) pc_if ();

    program_counter #(
        .WIDTH        (8),
        .RESET_VECTOR (8'h00)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pc_if (pc_if.slave)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    task automatic test_reset();
        reset        = 1'b1;
        pc_if.EN     = 1'b1;
        pc_if.PCNext = 8'h77;
        #10;
        checks++;
        if (pc_if.PC !== 8'h00 || pc_if.PCOld !== 8'h00 || pc_if.PCPlus1 !== 8'h01) begin
            errors++;
            $display("FAIL reset_async PC=%h PCOld=%h PCPlus1=%h required 00/00/01",
                     pc_if.PC, pc_if.PCOld, pc_if.PCPlus1);
        end
        // an EN=1 edge while reset is held must not load
        @(negedge clock);
        checks++;
        if (pc_if.PC !== 8'h00 || pc_if.PCOld !== 8'h00) begin
            errors++;
            $display("FAIL reset_edge_noload PC=%h PCOld=%h required 00/00", pc_if.PC, pc_if.PCOld);
        end
        reset        = 1'b0;
        pc_if.EN     = 1'b0;
        pc_if.PCNext = 8'hFF;
    endtask

    task automatic test_hold_after_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (pc_if.PC !== 8'h00 || pc_if.PCOld !== 8'h00 || pc_if.PCPlus1 !== 8'h01) begin
                errors++;
                $display("FAIL hold_after_reset[%0d] PC=%h PCOld=%h PCPlus1=%h required 00/00/01",
                         i, pc_if.PC, pc_if.PCOld, pc_if.PCPlus1);
            end
        end
    endtask

    task automatic test_load_wrap();
        pc_if.EN     = 1'b1;
        pc_if.PCNext = 8'hFF;
        @(negedge clock);
        checks++;
        if (pc_if.PC !== 8'hFF || pc_if.PCOld !== 8'h00 || pc_if.PCPlus1 !== 8'h00) begin
            errors++;
            $display("FAIL load_wrap PC=%h PCOld=%h PCPlus1=%h required FF/00/00",
                     pc_if.PC, pc_if.PCOld, pc_if.PCPlus1);
        end
    endtask

    task automatic test_hold();
        pc_if.EN     = 1'b0;
        pc_if.PCNext = 8'h12;
        @(negedge clock);
        checks++;
        if (pc_if.PC !== 8'hFF || pc_if.PCOld !== 8'h00 || pc_if.PCPlus1 !== 8'h00) begin
            errors++;
            $display("FAIL hold PC=%h PCOld=%h PCPlus1=%h required FF/00/00",
                     pc_if.PC, pc_if.PCOld, pc_if.PCPlus1);
        end
        // inputs changing mid-cycle must not reach the outputs
        pc_if.EN     = 1'b1;
        pc_if.PCNext = 8'hAA;
        #5;
        checks++;
        if (pc_if.PC !== 8'hFF || pc_if.PCOld !== 8'h00 || pc_if.PCPlus1 !== 8'h00) begin
            errors++;
            $display("FAIL no_comb_path PC=%h PCOld=%h PCPlus1=%h required FF/00/00",
                     pc_if.PC, pc_if.PCOld, pc_if.PCPlus1);
        end
        pc_if.EN = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] nxt [3];
        logic [7:0] old [3];
        nxt[0] = 8'h10; nxt[1] = 8'h11; nxt[2] = 8'h20;
        old[0] = 8'hFF; old[1] = 8'h10; old[2] = 8'h11;
        @(negedge clock);
        pc_if.EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_if.PCNext = nxt[i];
            @(negedge clock);
            checks++;
            if (pc_if.PC !== nxt[i] || pc_if.PCOld !== old[i] || pc_if.PCPlus1 !== nxt[i] + 8'h01) begin
                errors++;
                $display("FAIL back_to_back[%0d] PC=%h PCOld=%h PCPlus1=%h required %h/%h/%h",
                         i, pc_if.PC, pc_if.PCOld, pc_if.PCPlus1, nxt[i], old[i], nxt[i] + 8'h01);
            end
        end
        pc_if.EN = 1'b0;
    endtask

    task automatic test_same_value_load();
        pc_if.EN     = 1'b1;
        pc_if.PCNext = 8'h20;
        @(negedge clock);
        checks++;
        if (pc_if.PC !== 8'h20 || pc_if.PCOld !== 8'h20) begin
            errors++;
            $display("FAIL same_value_load PC=%h PCOld=%h required 20/20", pc_if.PC, pc_if.PCOld);
        end
        pc_if.EN = 1'b0;
    endtask

    task automatic test_async_reset();
        #10;
        reset = 1'b1;
        #1;
        checks++;
        if (pc_if.PC !== 8'h00 || pc_if.PCOld !== 8'h00 || pc_if.PCPlus1 !== 8'h01) begin
            errors++;
            $display("FAIL midcycle_reset PC=%h PCOld=%h PCPlus1=%h required 00/00/01",
                     pc_if.PC, pc_if.PCOld, pc_if.PCPlus1);
        end
        pc_if.EN     = 1'b1;
        pc_if.PCNext = 8'h55;
        @(negedge clock);
        checks++;
        if (pc_if.PC !== 8'h00 || pc_if.PCOld !== 8'h00) begin
            errors++;
            $display("FAIL reset_override PC=%h PCOld=%h required 00/00", pc_if.PC, pc_if.PCOld);
        end
        reset    = 1'b0;
        pc_if.EN = 1'b0;
        @(negedge clock);
        checks++;
        if (pc_if.PC !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_idle PC=%h required 00", pc_if.PC);
        end
        pc_if.EN     = 1'b1;
        pc_if.PCNext = 8'h33;
        @(negedge clock);
        checks++;
        if (pc_if.PC !== 8'h33 || pc_if.PCOld !== 8'h00 || pc_if.PCPlus1 !== 8'h34) begin
            errors++;
            $display("FAIL first_load_after_reset PC=%h PCOld=%h PCPlus1=%h required 33/00/34",
                     pc_if.PC, pc_if.PCOld, pc_if.PCPlus1);
        end
        pc_if.EN = 1'b0;
    endtask

`ifdef PC_LOAD_COUNT_EN
    task automatic test_load_count();
        #10;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        checks++;
        if (pc_if.LoadCount !== 16'd0) begin
            errors++;
            $display("FAIL load_count_reset LoadCount=%0d required 0", pc_if.LoadCount);
        end
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            pc_if.EN     = (i != 1);
            pc_if.PCNext = 8'(i + 1);
            @(negedge clock);
        end
        pc_if.EN = 1'b0;
        checks++;
        if (pc_if.LoadCount !== 16'd3) begin
            errors++;
            $display("FAIL load_count_three LoadCount=%0d required 3", pc_if.LoadCount);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (pc_if.LoadCount !== 16'd0) begin
            errors++;
            $display("FAIL load_count_clear LoadCount=%0d required 0", pc_if.LoadCount);
        end
        reset = 1'b0;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_hold_after_reset();
        test_load_wrap();
        test_hold();
        test_back_to_back();
        test_same_value_load();
        test_async_reset();
`ifdef PC_LOAD_COUNT_EN
        test_load_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
